// File: rtl/mbist_fault_ram.sv
// Single-port RAM responder for the MBIST controller with a programmable fault table,
// self-clearing init sweep and saturating access counters. Fault table built only with MBIST_FAULT_INJ_EN.
module mbist_fault_ram #(
  parameter int              ADDR     = 4,
  parameter int              DATA     = 8,
  parameter int              NFAULT   = 2,
  parameter logic [DATA-1:0] INIT_VAL = '0,
  localparam int             IW       = (NFAULT > 1) ? $clog2(NFAULT) : 1,
  localparam int             BW       = (DATA > 1) ? $clog2(DATA) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic            re,
  input  logic [ADDR-1:0] addr,
  input  logic [DATA-1:0] wdata,
  output logic [DATA-1:0] rdata,
  output logic            rvalid,
  input  logic            init_req,
  output logic            busy,
  output logic            init_done,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [IW-1:0]   cfg_idx,
  input  logic [ADDR-1:0] cfg_addr,
  input  logic [BW-1:0]   cfg_bit,
  input  logic [1:0]      cfg_type,
  output logic            err,
  output logic [15:0]     wr_count,
  output logic [15:0]     rd_count
);

  localparam int              DEPTH = 1 << ADDR;
  localparam logic [ADDR-1:0] LAST  = ADDR'(DEPTH - 1);

  localparam logic [1:0] F_NONE = 2'b00;
  localparam logic [1:0] F_SA0  = 2'b01;
  localparam logic [1:0] F_SA1  = 2'b10;
  localparam logic [1:0] F_RISE = 2'b11;

  typedef enum logic {S_IDLE, S_INIT} state_t;

  state_t          state, state_nxt;
  logic [ADDR-1:0] cnt;
  logic [DATA-1:0] mem [DEPTH];
  logic [DATA-1:0] rd_word, wr_word;
  logic            sweep_last, start, do_wr, do_rd, bad_strobe, cfg_bad;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state == S_INIT) ? cnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (init_req) state_nxt = S_INIT;
      S_INIT:  if (cnt == LAST) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy       = (state == S_INIT);
  assign cfg_ready  = !busy;
  assign sweep_last = busy && (cnt == LAST);
  assign start      = !busy && init_req;
  assign do_wr      = !busy && we && !re;
  assign do_rd      = !busy && re;
  // strobes during the sweep, or a write colliding with a read, are protocol errors
  assign bad_strobe = (busy && (we || re)) || (!busy && we && re);

  // ---------------- fault table ----------------
`ifdef MBIST_FAULT_INJ_EN
  typedef struct packed {
    logic [1:0]      typ;
    logic [ADDR-1:0] faddr;
    logic [BW-1:0]   fbit;
  } fault_t;

  fault_t [NFAULT-1:0] ftab;
  logic                cfg_fire, cfg_in_range;

  assign cfg_fire     = cfg_valid && cfg_ready;
  assign cfg_in_range = int'(cfg_idx) < NFAULT;
  assign cfg_bad      = cfg_fire && !cfg_in_range;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ftab <= '0;
    end else if (cfg_fire && cfg_in_range) begin
      ftab[cfg_idx] <= '{typ: cfg_type, faddr: cfg_addr, fbit: cfg_bit};
    end
  end

  // index order so the higher entry overrides a lower one on the same bit
  always_comb begin
    rd_word = mem[addr];
    for (int i = 0; i < NFAULT; i++) begin
      if (ftab[i].faddr == addr) begin
        if (ftab[i].typ == F_SA0) rd_word[ftab[i].fbit] = 1'b0;
        if (ftab[i].typ == F_SA1) rd_word[ftab[i].fbit] = 1'b1;
      end
    end
  end

  // a stored 0 under a rise-transition fault can never be written to 1
  always_comb begin
    wr_word = wdata;
    for (int i = 0; i < NFAULT; i++) begin
      if (ftab[i].typ == F_RISE && ftab[i].faddr == addr && !mem[addr][ftab[i].fbit])
        wr_word[ftab[i].fbit] = 1'b0;
    end
  end
`else
  logic cfg_unused;

  assign cfg_unused = ^{cfg_valid, cfg_idx, cfg_addr, cfg_bit, cfg_type, F_NONE, F_SA0, F_SA1, F_RISE};
  assign cfg_bad    = 1'b0;
  assign rd_word    = mem[addr];
  assign wr_word    = wdata;
`endif

  // ---------------- storage (not reset; cleared by the sweep) ----------------
  always_ff @(posedge clk) begin
    if (busy)
      mem[cnt] <= INIT_VAL;
    else if (do_wr)
      mem[addr] <= wr_word;
  end

  // ---------------- read port, status, counters ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata     <= '0;
      rvalid    <= 1'b0;
      init_done <= 1'b0;
      err       <= 1'b0;
      wr_count  <= '0;
      rd_count  <= '0;
    end else begin
      rvalid    <= do_rd;
      init_done <= sweep_last;
      if (do_rd) rdata <= rd_word;
      if (bad_strobe || cfg_bad) err <= 1'b1;
      if (start) begin
        wr_count <= '0;
        rd_count <= '0;
      end else begin
        if (do_wr && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
        if (do_rd && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end

endmodule
